serial_add_sequencer: RTL
=========================

// Module: serial_add_sequencer
// PURPOSE
//  Bit-serial adder controller. It drives a single 1-bit full-adder slice
//  (sum = a^b^c, carry = majority(a,b,c)) for WIDTH cycles, LSB first, and
//  keeps the carry in a flip-flop between bits, so one FA cell performs a
//  WIDTH-bit add. It sits between a requester (start/done handshake) and the
//  FA datapath, and holds the result until the next accepted request.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; legal range >= 1
// PORTS
//  clk     in   1      rising-edge clock (single clock domain)
//  rst_n   in   1      asynchronous, active-low reset
//  start   in   1      request; sampled only in IDLE
//  a       in   WIDTH  operand A; captured on the accepting edge
//  b       in   WIDTH  operand B; captured on the accepting edge
//  cin     in   1      carry-in; captured on the accepting edge
//  busy    out  1      high while in RUN
//  done    out  1      one-cycle pulse; result valid from this cycle onward
//  sum     out  WIDTH  registered result, held until the next completion
//  cout    out  1      registered carry-out, held with sum
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0.
//    Operand shift registers, carry flop and bit counter are cleared.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE -> RUN on an edge with start=1. That edge loads a_sh=a, b_sh=b,
//      carry=cin and cnt=0.
//    RUN: each edge computes s=a_sh[0]^b_sh[0]^carry and
//      carry<=(a_sh[0]&b_sh[0])|(carry&(a_sh[0]^b_sh[0])).
//      It shifts a_sh and b_sh right by one, shifts s into the MSB of the
//      internal acc register (right shift), and does cnt<=cnt+1.
//      On the edge where cnt==WIDTH-1, the FSM goes to DONE. On that same
//      edge, sum<={s,acc[WIDTH-1:1]} and cout<=next carry.
//    DONE -> IDLE unconditionally on the next edge.
//  - Outputs: busy = (state==RUN); done = (state==DONE). Both are decoded from
//    registered state, so they are glitch-free.
//  - Latency: when start is accepted at edge E0, done is high in the cycle
//    after edge E0+WIDTH. The earliest next accept is at edge E0+WIDTH+2.
//    Throughput is one add per WIDTH+2 cycles.
//  - sum/cout change only on the completion edge. They never show partial
//    results and stay stable while busy.
//  - start is ignored in RUN and DONE; requests made there are not queued.
//  - Operand inputs may change freely after the accepting edge without
//    affecting the running add.
//  - Arithmetic: {cout,sum} == a + b + cin, computed modulo 2^(WIDTH+1).
//  - cnt is $clog2(WIDTH)+1 bits wide and never wraps during RUN.
//  - WIDTH=1: the FSM spends one cycle in RUN, then DONE.
//  - Reset asserted mid-RUN or in DONE: the FSM returns to IDLE immediately.
//    busy, done, sum and cout clear, and no done pulse is emitted for the
//    aborted add.
// TESTING
//  1 Reset: with rst_n=0 asynchronously mid-cycle -> busy=0, done=0, sum=0,
//    cout=0 before the next edge.
//  2 WIDTH=8, a=8'hFF, b=8'h01, cin=0, start pulsed at E0 -> busy high for
//    8 cycles; done high exactly in the cycle after E0+8; sum=8'h00, cout=1.
//  3 a=8'hA5, b=8'h5A with cin=0 -> sum=8'hFF, cout=0. Repeat with cin=1 ->
//    sum=8'h00, cout=1. Also check a=b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
//  4 start held high continuously, operands changed every cycle while busy ->
//    only the operands at the accepting edges are used; accepts are spaced
//    exactly 10 cycles apart; sum stays constant between done pulses.
//  5 rst_n pulsed low at the 4th RUN cycle -> no done pulse, outputs zero.
//    A fresh start then gives a correct result (0x00+0x00, cin=1 -> 0x01).
//  6 Run 1000 random a/b/cin for WIDTH=8 and WIDTH=1 against the scoreboard
//    model a+b+cin -> zero mismatches; busy and done are never high together.

Source files
------------

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial adder controller driving one full-adder slice
module serial_add_sequencer #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e           state_q;
   logic [WIDTH-1:0] a_sh_q;
   logic [WIDTH-1:0] b_sh_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] sum_q;
   logic             carry_q;
   logic             cout_q;
   logic             busy_q;
   logic             done_q;
   logic [CW-1:0]    cnt_q;

   logic             bit_s_d;
   logic             carry_d;
   logic [WIDTH-1:0] s_msb;
   logic [WIDTH-1:0] acc_d;

   // Single full-adder slice on the current LSBs, plus the accumulator with the new bit entering at the MSB
   always_comb begin
      bit_s_d         = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
      carry_d         = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
      s_msb           = '0;
      s_msb[WIDTH-1]  = bit_s_d;
      acc_d           = (acc_q >> 1) | s_msb;
   end

   // Sequencer: accept in IDLE, one bit per cycle in RUN, publish result on the last bit, one-cycle DONE
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= IDLE;
         a_sh_q  <= '0;
         b_sh_q  <= '0;
         acc_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  a_sh_q  <= a_i;
                  b_sh_q  <= b_i;
                  carry_q <= cin_i;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               a_sh_q  <= a_sh_q >> 1;
               b_sh_q  <= b_sh_q >> 1;
               carry_q <= carry_d;
               acc_q   <= acc_d;
               cnt_q   <= cnt_q + CW'(1);
               if (cnt_q == LAST_BIT) begin
                  sum_q   <= acc_d;
                  cout_q  <= carry_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign sum_o  = sum_q;
   assign cout_o = cout_q;

endmodule
